// File: rtl/led_matrix_scan_engine.sv
// Parametrised ROWS x COLS LED matrix scanner with per-step blanking, runtime dwell,
// raster/row/hold scan modes, pause/resume and a registered frame marker.
module led_matrix_scan_engine #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [ROWS-1:0]          led_row,
    output logic [COLS-1:0]          led_col,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic [$clog2(COLS)-1:0]  col_idx,
    output logic                     pixel_valid,
    output logic                     frame_start
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DWELL
    } state_t;

    state_t               r_state,     w_state_nx;
    logic [RW-1:0]        r_row,       w_row_nx;
    logic [CW-1:0]        r_col,       w_col_nx;
    logic [DWELL_W-1:0]   r_dwell_cnt, w_dwell_cnt_nx;
    logic [BW-1:0]        r_blank_cnt, w_blank_cnt_nx;
    logic [1:0]           r_mode,      w_mode_nx;
    logic                 w_enter_dwell;
    logic [DWELL_W-1:0]   w_dwell_load;
    logic [ROWS-1:0]      w_led_row_nx;
    logic [COLS-1:0]      w_led_col_nx;
    logic                 w_lit_nx;
    logic                 w_frame_start_nx;

    // Both counters run down to zero, so a dwell of 0 or 1 loads 0 and lights one cycle.
    assign w_dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        w_state_nx     = r_state;
        w_row_nx       = r_row;
        w_col_nx       = r_col;
        w_dwell_cnt_nx = r_dwell_cnt;
        w_blank_cnt_nx = r_blank_cnt;
        w_mode_nx      = r_mode;
        w_enter_dwell  = 1'b0;

        if (!en) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (BLANK_CYCLES == 0) begin
                        w_enter_dwell = 1'b1;
                    end else begin
                        w_state_nx     = S_BLANK;
                        w_blank_cnt_nx = BLANK_LAST;
                    end
                end
                S_BLANK: begin
                    if (r_blank_cnt == '0) w_enter_dwell = 1'b1;
                    else                   w_blank_cnt_nx = r_blank_cnt - 1'b1;
                end
                S_DWELL: begin
                    if (r_dwell_cnt == '0) begin
                        // Step boundary: advance with the mode presented right now.
                        case (mode)
                            2'd1: begin
                                w_col_nx = '0;
                                w_row_nx = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                            end
                            2'd2: ;
                            default: begin
                                if (r_col == COL_LAST) begin
                                    w_col_nx = '0;
                                    w_row_nx = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                                end else begin
                                    w_col_nx = r_col + 1'b1;
                                end
                            end
                        endcase
                        if (BLANK_CYCLES == 0) begin
                            w_enter_dwell = 1'b1;
                        end else begin
                            w_state_nx     = S_BLANK;
                            w_blank_cnt_nx = BLANK_LAST;
                        end
                    end else begin
                        w_dwell_cnt_nx = r_dwell_cnt - 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end

        if (w_enter_dwell) begin
            w_state_nx     = S_DWELL;
            w_dwell_cnt_nx = w_dwell_load;
            w_mode_nx      = mode;
        end

        w_lit_nx         = (w_state_nx == S_DWELL);
        w_led_row_nx     = w_lit_nx ? (ROWS'(1) << w_row_nx) : '0;
        w_led_col_nx     = !w_lit_nx ? '0 :
                           (w_mode_nx == 2'd1) ? '1 : (COLS'(1) << w_col_nx);
        w_frame_start_nx = w_enter_dwell && (w_row_nx == '0) && (w_col_nx == '0)
                           && (w_mode_nx != 2'd2);
    end

    // NOTE: state is updated only with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_dwell_cnt <= '0;
            r_blank_cnt <= '0;
            r_mode      <= '0;
            led_row     <= '0;
            led_col     <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_row       <= w_row_nx;
            r_col       <= w_col_nx;
            r_dwell_cnt <= w_dwell_cnt_nx;
            r_blank_cnt <= w_blank_cnt_nx;
            r_mode      <= w_mode_nx;
            led_row     <= w_led_row_nx;
            led_col     <= w_led_col_nx;
            pixel_valid <= w_lit_nx;
            frame_start <= w_frame_start_nx;
        end
    end

    assign row_idx = r_row;
    assign col_idx = r_col;

endmodule

// File: tb/tb_led_matrix_scan_engine.sv
// Bench for led_matrix_scan_engine: two 4x4 instances (BLANK_CYCLES=1 and 0) share stimulus
// and are compared every cycle against a step-level behavioural model.
module tb_led_matrix_scan_engine;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [DWELL_W-1:0] dwell = 16'd3;

    logic [ROWS-1:0] b0_led_row, b1_led_row;
    logic [COLS-1:0] b0_led_col, b1_led_col;
    logic [1:0]      b0_row_idx, b1_row_idx, b0_col_idx, b1_col_idx;
    logic            b0_pixel_valid, b1_pixel_valid, b0_frame_start, b1_frame_start;

    always #5 clk = ~clk;

    led_matrix_scan_engine #(.ROWS(ROWS), .COLS(COLS), .DWELL_W(DWELL_W), .BLANK_CYCLES(0)) u_dut_b0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell),
        .led_row(b0_led_row), .led_col(b0_led_col), .row_idx(b0_row_idx), .col_idx(b0_col_idx),
        .pixel_valid(b0_pixel_valid), .frame_start(b0_frame_start)
    );

    led_matrix_scan_engine #(.ROWS(ROWS), .COLS(COLS), .DWELL_W(DWELL_W), .BLANK_CYCLES(1)) u_dut_b1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell),
        .led_row(b1_led_row), .led_col(b1_led_col), .row_idx(b1_row_idx), .col_idx(b1_col_idx),
        .pixel_valid(b1_pixel_valid), .frame_start(b1_frame_start)
    );

    // Model: scanning on/off, blanking or lit, cycles left in the current phase, position.
    typedef struct packed {
        logic       active;
        logic       lit;
        logic       first;
        logic [1:0] disp_mode;
        int         blank_left;
        int         lit_left;
        int         row;
        int         col;
    } model_t;

    model_t mdl0, mdl1;
    int vectors = 0, miscompares = 0;
    int cyc = 0, last_fs = -1, fs_gap = 0;
    bit found;

    function automatic model_t begin_lit(model_t m);
        m.lit       = 1'b1;
        m.first     = 1'b1;
        m.disp_mode = mode;
        m.lit_left  = (dwell == 0) ? 1 : int'(dwell);
        return m;
    endfunction

    function automatic model_t start_step(model_t m, int b);
        if (b > 0) begin
            m.lit        = 1'b0;
            m.first      = 1'b0;
            m.blank_left = b;
        end else begin
            m = begin_lit(m);
        end
        return m;
    endfunction

    function automatic model_t model_next(model_t m, int b);
        int idx;
        if (rst) begin
            m = '0;
        end else if (!en) begin
            m.active = 1'b0;
            m.lit    = 1'b0;
            m.first  = 1'b0;
        end else if (!m.active) begin
            m.active = 1'b1;
            m = start_step(m, b);
        end else if (!m.lit) begin
            if (m.blank_left == 1) m = begin_lit(m);
            else                   m.blank_left--;
        end else begin
            m.first = 1'b0;
            if (m.lit_left == 1) begin
                if (mode == 2'd1) begin
                    m.row = (m.row + 1) % ROWS;
                    m.col = 0;
                end else if (mode != 2'd2) begin
                    idx   = (m.row * COLS + m.col + 1) % (ROWS * COLS);
                    m.row = idx / COLS;
                    m.col = idx % COLS;
                end
                m = start_step(m, b);
            end else begin
                m.lit_left--;
            end
        end
        return m;
    endfunction

    function automatic logic [13:0] expect_of(model_t m);
        logic [3:0] r, c;
        logic       fs;
        r  = m.lit ? 4'(1 << m.row) : 4'h0;
        c  = !m.lit ? 4'h0 : ((m.disp_mode == 2'd1) ? 4'hF : 4'(1 << m.col));
        fs = m.lit && m.first && (m.row == 0) && (m.col == 0) && (m.disp_mode != 2'd2);
        return {r, c, 2'(m.row), 2'(m.col), m.lit, fs};
    endfunction

    task automatic check_vec(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed {row,col,ri,ci,pv,fs}=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        mdl0 = model_next(mdl0, 0);
        mdl1 = model_next(mdl1, 1);
        @(posedge clk);
        #1;
        cyc++;
        check_vec("blank0_outputs", {b0_led_row, b0_led_col, b0_row_idx, b0_col_idx, b0_pixel_valid, b0_frame_start},
                  expect_of(mdl0));
        check_vec("blank1_outputs", {b1_led_row, b1_led_col, b1_row_idx, b1_col_idx, b1_pixel_valid, b1_frame_start},
                  expect_of(mdl1));
        if (b1_frame_start) begin
            if (last_fs >= 0) fs_gap = cyc - last_fs;
            last_fs = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        mdl0 = '0;
        mdl1 = '0;

        // Reset held three cycles with the scan disabled, then idle.
        rst = 1'b1; en = 1'b0;
        ticks(3);
        rst = 1'b0;
        ticks(2);

        // First step: one blank cycle then three lit cycles at (0,0).
        en = 1'b1; mode = 2'd0; dwell = 16'd3;
        ticks(5);

        // Raster over two-plus frames with dwell 2; frame period 16 * 3.
        dwell = 16'd2; last_fs = -1; fs_gap = 0;
        ticks(120);
        check_int("frame_gap_mode0", fs_gap, ROWS * COLS * 3);

        // Row scan with all columns lit; frame period 4 * 3.
        mode = 2'd1; last_fs = -1; fs_gap = 0;
        ticks(40);
        check_int("frame_gap_mode1", fs_gap, ROWS * 3);

        // Dwell 0 behaves as 1.
        mode = 2'd0; dwell = 16'd0;
        ticks(20);

        // Dwell changed mid-step: current step keeps 5, the next uses 2.
        dwell = 16'd5;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = mdl1.lit && mdl1.first;
        end
        check_int("reach_dwell5_step", int'(found), 1);
        ticks(2);
        dwell = 16'd2;
        ticks(15);

        // Pause in the middle of (2,1), then resume at the same position.
        dwell = 16'd3;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            found = mdl1.lit && mdl1.row == 2 && mdl1.col == 1 && mdl1.lit_left == 2;
        end
        check_int("reach_pos_2_1", int'(found), 1);
        en = 1'b0;
        ticks(3);
        en = 1'b1;
        ticks(8);

        // Hold at (1,3) for ten steps, then reset mid-dwell.
        dwell = 16'd2;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            found = mdl1.lit && mdl1.first && mdl1.row == 1 && mdl1.col == 3;
        end
        check_int("reach_pos_1_3", int'(found), 1);
        mode = 2'd2;
        ticks(30);
        check_int("hold_row", int'(b1_row_idx), 1);
        check_int("hold_col", int'(b1_col_idx), 3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = mdl1.lit && mdl1.lit_left > 1;
        end
        check_int("reach_mid_dwell", int'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 2'd0;
        ticks(4);

        // Randomised mix of modes, dwells, pauses and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  dwell = 16'($urandom_range(0, 4));
            en  = ($urandom_range(0, 29) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
